porta_motor: RTL and testbench

//  Door mechanism side of the "Sistema Porta" lab: consumes open/close/stop commands and

---
 rtl/porta_pkg.sv | 33 +++
 rtl/porta_prescaler.sv | 29 ++
 rtl/porta_motor.sv | 138 +++++++++++++
 tb/tb_porta_motor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/porta_pkg.sv
// Shared door definitions: state encoding and active-low 7-segment status letters.
// The door controller uses the same package.
package porta_pkg;

  typedef enum logic [2:0] {
    FECHADA  = 3'd0,
    ABRINDO  = 3'd1,
    ABERTA   = 3'd2,
    FECHANDO = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment
  localparam logic [6:0] HEX_F = 7'b0001110;
  localparam logic [6:0] HEX_A = 7'b0001000;
  localparam logic [6:0] HEX_O = 7'b1000000;
  localparam logic [6:0] HEX_C = 7'b1000110;
  localparam logic [6:0] HEX_P = 7'b0001100;

  function automatic logic [6:0] hex_letter(input estado_t e);
    logic [6:0] h;
    case (e)
      FECHADA:  h = HEX_F;
      ABRINDO:  h = HEX_A;
      ABERTA:   h = HEX_O;
      FECHANDO: h = HEX_C;
      PARADA:   h = HEX_P;
      default:  h = HEX_F;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/porta_prescaler.sv
// Movement prescaler: free-running 0..DIV-1 counter, tick marks the last count.
// With DIV=1 the counter stays at zero and tick is high every cycle.
module porta_prescaler #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == LAST);

  // count cycles, wrapping after the tick cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

endmodule

// File: rtl/porta_motor.sv
// Motorised door model: open/close/stop FSM moving a saturating position counter,
// with auto-close hold timer, obstacle reversal, limit sensors, LEDs and status letter.
module porta_motor
  import porta_pkg::*;
#(
  parameter  int CURSO        = 8,
  parameter  int DIV          = 1,
  parameter  int TEMPO_ABERTA = 16,
  localparam int PW           = $clog2(CURSO + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          abrir,
  input  logic          fechar,
  input  logic          parar,
  input  logic          obstaculo,
  output logic          sensor_aberta,
  output logic          sensor_fechada,
  output logic [PW-1:0] posicao,
  output logic          ledVerde,
  output logic          ledVermelho,
  output logic [6:0]    HEX
);

  localparam int HW = (TEMPO_ABERTA > 1) ? $clog2(TEMPO_ABERTA) : 1;
  localparam logic [PW-1:0] CURSO_P   = PW'(CURSO);
  localparam logic [HW-1:0] HOLD_LAST = HW'((TEMPO_ABERTA > 0) ? TEMPO_ABERTA - 1 : 0);

  estado_t       estado_r, estado_s;
  logic [PW-1:0] pos_r, pos_s, pos_inc_s, pos_dec_s;
  logic [HW-1:0] hold_r, hold_s;
  logic          tick_s;
  logic          sensor_aberta_r, sensor_fechada_r, led_verde_r, led_vermelho_r;
  logic [6:0]    hex_r;

  porta_prescaler #(.DIV(DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick_s)
  );

  assign pos_inc_s = (pos_r == CURSO_P) ? pos_r : pos_r + 1'b1;
  assign pos_dec_s = (pos_r == {PW{1'b0}}) ? pos_r : pos_r - 1'b1;

  // next state; a command-driven transition never moves the door in the same cycle
  always_comb begin
    estado_s = estado_r;
    pos_s    = pos_r;
    hold_s   = hold_r;
    case (estado_r)
      FECHADA: begin
        if (abrir && !parar) estado_s = ABRINDO;
        else                 estado_s = FECHADA;
      end
      ABRINDO: begin
        if (parar)       estado_s = PARADA;
        else if (fechar) estado_s = FECHANDO;
        else if (tick_s) begin
          pos_s = pos_inc_s;
          if (pos_inc_s == CURSO_P) begin
            estado_s = ABERTA;
            hold_s   = '0;
          end else begin
            estado_s = ABRINDO;
          end
        end else begin
          estado_s = ABRINDO;
        end
      end
      ABERTA: begin
        if (parar)       estado_s = PARADA;
        else if (fechar) estado_s = FECHANDO;
        else if (abrir)  hold_s   = '0;
        else if (tick_s && (TEMPO_ABERTA > 0)) begin
          // a zero hold time disables auto-close, so the timer simply idles
          if (hold_r == HOLD_LAST) estado_s = FECHANDO;
          else                     hold_s   = hold_r + 1'b1;
        end else begin
          hold_s = hold_r;
        end
      end
      FECHANDO: begin
        if (parar)                 estado_s = PARADA;
        else if (obstaculo)        estado_s = ABRINDO;
        else if (abrir && !fechar) estado_s = ABRINDO;
        else if (tick_s) begin
          pos_s = pos_dec_s;
          if (pos_dec_s == {PW{1'b0}}) estado_s = FECHADA;
          else                         estado_s = FECHANDO;
        end else begin
          estado_s = FECHANDO;
        end
      end
      PARADA: begin
        if (parar)       estado_s = PARADA;
        else if (fechar) estado_s = FECHANDO;
        else if (abrir)  estado_s = ABRINDO;
        else             estado_s = PARADA;
      end
      default: begin
        estado_s = FECHADA;
        pos_s    = '0;
        hold_s   = '0;
      end
    endcase
  end

  // state registers plus outputs decoded one cycle early from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r         <= FECHADA;
      pos_r            <= '0;
      hold_r           <= '0;
      sensor_aberta_r  <= 1'b0;
      sensor_fechada_r <= 1'b1;
      led_verde_r      <= 1'b0;
      led_vermelho_r   <= 1'b1;
      hex_r            <= HEX_F;
    end else begin
      estado_r         <= estado_s;
      pos_r            <= pos_s;
      hold_r           <= hold_s;
      sensor_aberta_r  <= (pos_s == CURSO_P);
      sensor_fechada_r <= (pos_s == {PW{1'b0}});
      led_verde_r      <= (estado_s == ABERTA);
      led_vermelho_r   <= (estado_s == FECHADA) || (estado_s == PARADA);
      hex_r            <= hex_letter(estado_s);
    end
  end

  assign posicao        = pos_r;
  assign sensor_aberta  = sensor_aberta_r;
  assign sensor_fechada = sensor_fechada_r;
  assign ledVerde       = led_verde_r;
  assign ledVermelho    = led_vermelho_r;
  assign HEX            = hex_r;

endmodule

// File: tb/tb_porta_motor.sv
// Bench for porta_motor: DIV=1 and DIV=3 instances share stimulus and are
// compared every cycle against an arithmetic door model, plus directed checks.
module tb_porta_motor;

  localparam int CURSO = 4;
  localparam int TEMPO = 3;
  localparam int S_F = 0, S_A = 1, S_O = 2, S_C = 3, S_P = 4;

  logic clock = 1'b0;
  logic reset, abrir, fechar, parar, obstaculo;
  logic       sa_o [2];
  logic       sf_o [2];
  logic [2:0] pos_o[2];
  logic       lg_o [2];
  logic       lr_o [2];
  logic [6:0] hex_o[2];

  int vectors = 0;
  int miscompares = 0;

  // reference door: state code, position, hold time, edges since reset
  int st[2], pos[2], hold[2], cyc[2];
  int dv[2] = '{1, 3};
  logic [6:0] letter[5] = '{7'b0001110, 7'b0001000, 7'b1000000, 7'b1000110, 7'b0001100};

  always #5 clock = ~clock;

  porta_motor #(.CURSO(CURSO), .DIV(1), .TEMPO_ABERTA(TEMPO)) dut1 (
    .clock(clock), .reset(reset), .abrir(abrir), .fechar(fechar), .parar(parar),
    .obstaculo(obstaculo), .sensor_aberta(sa_o[0]), .sensor_fechada(sf_o[0]),
    .posicao(pos_o[0]), .ledVerde(lg_o[0]), .ledVermelho(lr_o[0]), .HEX(hex_o[0]));

  porta_motor #(.CURSO(CURSO), .DIV(3), .TEMPO_ABERTA(TEMPO)) dut3 (
    .clock(clock), .reset(reset), .abrir(abrir), .fechar(fechar), .parar(parar),
    .obstaculo(obstaculo), .sensor_aberta(sa_o[1]), .sensor_fechada(sf_o[1]),
    .posicao(pos_o[1]), .ledVerde(lg_o[1]), .ledVermelho(lr_o[1]), .HEX(hex_o[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int k);
    bit tick;
    if (reset) begin
      st[k] = S_F; pos[k] = 0; hold[k] = 0; cyc[k] = 0;
      return;
    end
    tick = (cyc[k] % dv[k]) == (dv[k] - 1);
    cyc[k]++;
    case (st[k])
      S_F: if (abrir && !parar) st[k] = S_A;
      S_A: begin
        if (parar) st[k] = S_P;
        else if (fechar) st[k] = S_C;
        else if (tick) begin
          if (pos[k] < CURSO) pos[k]++;
          if (pos[k] == CURSO) begin st[k] = S_O; hold[k] = 0; end
        end
      end
      S_O: begin
        if (parar) st[k] = S_P;
        else if (fechar) st[k] = S_C;
        else if (abrir) hold[k] = 0;
        else if (tick) begin
          if (hold[k] == TEMPO - 1) st[k] = S_C;
          else hold[k]++;
        end
      end
      S_C: begin
        if (parar) st[k] = S_P;
        else if (obstaculo) st[k] = S_A;
        else if (abrir && !fechar) st[k] = S_A;
        else if (tick) begin
          if (pos[k] > 0) pos[k]--;
          if (pos[k] == 0) st[k] = S_F;
        end
      end
      default: begin
        if (!parar) begin
          if (fechar) st[k] = S_C;
          else if (abrir) st[k] = S_A;
        end
      end
    endcase
  endtask

  task automatic check_dut(input int k);
    string n;
    n = (k == 0) ? "div1" : "div3";
    chk({n, ".posicao"}, pos_o[k], pos[k]);
    chk({n, ".sensor_aberta"}, sa_o[k], pos[k] == CURSO);
    chk({n, ".sensor_fechada"}, sf_o[k], pos[k] == 0);
    chk({n, ".ledVerde"}, lg_o[k], st[k] == S_O);
    chk({n, ".ledVermelho"}, lr_o[k], (st[k] == S_F) || (st[k] == S_P));
    chk({n, ".HEX"}, hex_o[k], letter[st[k]]);
  endtask

  task automatic step();
    @(posedge clock);
    model(0);
    model(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic pulse_abrir();
    abrir = 1'b1; step(); abrir = 1'b0;
  endtask

  initial begin
    reset = 1'b1; abrir = 1'b0; fechar = 1'b0; parar = 1'b0; obstaculo = 1'b0;
    step(); step();
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) step();
    chk("idle.HEX", hex_o[0], 7'b0001110);
    chk("idle.sf", sf_o[0], 1'b1);
    chk("idle.lr", lr_o[0], 1'b1);
    chk("idle.lg", lg_o[0], 1'b0);

    // 2: open run
    pulse_abrir();
    chk("open.HEX_A", hex_o[0], 7'b0001000);
    chk("open.pos0", pos_o[0], 3'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("open.pos", pos_o[0], i);
    end
    chk("open.sa", sa_o[0], 1'b1);
    chk("open.lg", lg_o[0], 1'b1);
    chk("open.HEX_O", hex_o[0], 7'b1000000);

    // 3: auto-close after hold time
    step(); step();
    chk("hold.HEX_O", hex_o[0], 7'b1000000);
    step();
    chk("autoclose.HEX_C", hex_o[0], 7'b1000110);
    for (int i = 3; i >= 0; i--) begin
      step();
      chk("close.pos", pos_o[0], i);
    end
    chk("close.HEX_F", hex_o[0], 7'b0001110);

    // 4: obstacle reversal at position 2
    pulse_abrir();
    for (int i = 0; i < 30 && !(st[0] == S_C && pos[0] == 2); i++) step();
    chk("obst.reach", (st[0] == S_C && pos[0] == 2), 1'b1);
    chk("obst.pos_before", pos_o[0], 3'd2);
    obstaculo = 1'b1; step(); obstaculo = 1'b0;
    chk("obst.HEX_A", hex_o[0], 7'b0001000);
    chk("obst.pos_hold", pos_o[0], 3'd2);
    step(); step();
    chk("obst.pos4", pos_o[0], 3'd4);

    // 5: stop while opening, then close from stop
    for (int i = 0; i < 30 && st[0] != S_F; i++) step();
    chk("stop.closed", st[0] == S_F, 1'b1);
    pulse_abrir();
    step(); step();
    chk("stop.pos_before", pos_o[0], 3'd2);
    parar = 1'b1; fechar = 1'b1; step();
    chk("stop.HEX_P", hex_o[0], 7'b0001100);
    chk("stop.lr", lr_o[0], 1'b1);
    step(); step();
    chk("stop.frozen", pos_o[0], 3'd2);
    parar = 1'b0; step();
    chk("stop.HEX_C", hex_o[0], 7'b1000110);
    for (int i = 0; i < 10 && st[0] != S_F; i++) step();
    chk("stop.sf", sf_o[0], 1'b1);
    fechar = 1'b0;

    // 6: reset mid-motion, then DIV=3 open run
    pulse_abrir();
    for (int i = 0; i < 10 && pos[0] != 3; i++) step();
    chk("rst.pos3", pos_o[0], 3'd3);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst.pos0", pos_o[0], 3'd0);
    chk("rst.HEX_F", hex_o[0], 7'b0001110);
    pulse_abrir();
    chk("div3.pos0", pos_o[1], 3'd0);
    for (int i = 0; i < 8; i++) step();
    chk("div3.pos3", pos_o[1], 3'd3);
    for (int i = 0; i < 3; i++) step();
    chk("div3.pos4", pos_o[1], 3'd4);
    chk("div3.HEX_O", hex_o[1], 7'b1000000);

    // random command mix, occasional reset
    for (int i = 0; i < 600; i++) begin
      abrir     = ($urandom_range(99) < 30);
      fechar    = ($urandom_range(99) < 15);
      parar     = ($urandom_range(99) < 8);
      obstaculo = ($urandom_range(99) < 15);
      reset     = ($urandom_range(99) < 2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
